// File: rtl/collision_checker.sv
`default_nettype none
// ============================================================================
//  Module      : collision_checker (with collision_pkg)
//  Description : Once-per-frame T-Rex / front-obstacle collision test.
//                The first stage compares the inset outer bounding boxes.
//                On an overlap, the second stage walks every T-Rex/obstacle
//                collision-box pair, one pair per cycle, through a single
//                shared overlap comparator. Any hit sets the sticky crash
//                flag and records the first hitting pair.
//  Ports       : clk, rst (sync, active-low)
//                update, enable, clear, obstacle_valid : control inputs
//                trex_x/y/w/h, obstacle_x/y/w/h        : outer boxes
//                trex_box[], obstacle_box[]            : relative boxes
//                busy, done, crash, hit_trex_idx, hit_obst_idx : results
//  Revision    : 1.0 - initial release
// ============================================================================

package collision_pkg;
  // Collision box offset and size, measured from the owner's origin.
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
    logic [7:0] h;
  } collision_box_t;
endpackage

module collision_checker #(
  parameter int TREX_BOXES = 6,
  parameter int OBST_BOXES = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          update,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          obstacle_valid,
  input  logic signed [10:0]            trex_x,
  input  logic [9:0]                    trex_y,
  input  logic [9:0]                    trex_w,
  input  logic [9:0]                    trex_h,
  input  logic signed [10:0]            obstacle_x,
  input  logic [9:0]                    obstacle_y,
  input  logic [9:0]                    obstacle_w,
  input  logic [9:0]                    obstacle_h,
  input  collision_pkg::collision_box_t trex_box     [TREX_BOXES],
  input  collision_pkg::collision_box_t obstacle_box [OBST_BOXES],
  output logic                          busy,
  output logic                          done,
  output logic                          crash,
  output logic [2:0]                    hit_trex_idx,
  output logic [2:0]                    hit_obst_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OUTER  = 2'd1,
    S_PAIRS  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [2:0] c_last_i = 3'(TREX_BOXES - 1);
  localparam logic [2:0] c_last_j = 3'(OBST_BOXES - 1);

  state_t r_state;
  state_t w_next;

  // Origins and outer sizes captured when a check starts.
  logic signed [11:0] r_tx, r_ty, r_tw, r_th;
  logic signed [11:0] r_ox, r_oy, r_ow, r_oh;

  logic [2:0] r_i, r_j;
  logic       r_crash;
  logic [2:0] r_hit_i, r_hit_j;
  logic       r_nv_done;

  logic w_start;
  logic w_no_obst;
  logic w_pair_hit;
  logic w_last;

  // Shared comparator operands.
  collision_pkg::collision_box_t w_tb, w_ob;
  logic signed [11:0] w_ax, w_ay, w_aw, w_ah;
  logic signed [11:0] w_bx, w_by, w_bw, w_bh;
  logic               w_empty;
  logic               w_overlap;

  // --------------------------------------------------------------------------
  // Operand mux: outer boxes in OUTER, the current box pair otherwise.
  // --------------------------------------------------------------------------
  always_comb begin
    w_tb = trex_box[r_i];
    w_ob = obstacle_box[r_j];
    if (r_state == S_OUTER) begin
      // Outer boxes are shrunk by one pixel on every side.
      w_ax    = r_tx + 12'sd1;
      w_ay    = r_ty + 12'sd1;
      w_aw    = r_tw - 12'sd2;
      w_ah    = r_th - 12'sd2;
      w_bx    = r_ox + 12'sd1;
      w_by    = r_oy + 12'sd1;
      w_bw    = r_ow - 12'sd2;
      w_bh    = r_oh - 12'sd2;
      w_empty = 1'b0;
    end else begin
      w_ax    = r_tx + $signed({4'b0000, w_tb.x});
      w_ay    = r_ty + $signed({4'b0000, w_tb.y});
      w_aw    = $signed({4'b0000, w_tb.w});
      w_ah    = $signed({4'b0000, w_tb.h});
      w_bx    = r_ox + $signed({4'b0000, w_ob.x});
      w_by    = r_oy + $signed({4'b0000, w_ob.y});
      w_bw    = $signed({4'b0000, w_ob.w});
      w_bh    = $signed({4'b0000, w_ob.h});
      // Unused box slots are encoded as zero size and must never hit.
      w_empty = (w_tb.w == 8'd0) || (w_tb.h == 8'd0) ||
                (w_ob.w == 8'd0) || (w_ob.h == 8'd0);
    end
    w_overlap = !w_empty &&
                (w_ax < w_bx + w_bw) && (w_ax + w_aw > w_bx) &&
                (w_ay < w_by + w_bh) && (w_ay + w_ah > w_by);
  end

  assign w_last = (r_i == c_last_i) && (r_j == c_last_j);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_no_obst  = 1'b0;
    w_pair_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (update && enable && !r_crash) begin
          if (obstacle_valid) begin
            w_next  = S_OUTER;
            w_start = 1'b1;
          end else begin
            w_no_obst = 1'b1;
          end
        end
      end
      S_OUTER: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (w_overlap) begin
          w_next = S_PAIRS;
        end else begin
          w_next = S_FINISH;
        end
      end
      S_PAIRS: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (w_overlap) begin
          w_pair_hit = 1'b1;
          w_next     = S_FINISH;
        end else if (w_last) begin
          w_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: snapshots, pair counters, sticky crash and hit indices
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx      <= '0;
      r_ty      <= '0;
      r_tw      <= '0;
      r_th      <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_ow      <= '0;
      r_oh      <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_crash   <= 1'b0;
      r_hit_i   <= '0;
      r_hit_j   <= '0;
      r_nv_done <= 1'b0;
    end else begin
      r_nv_done <= w_no_obst;

      if (w_start) begin
        r_tx <= {trex_x[10], trex_x};
        r_ty <= {2'b00, trex_y};
        r_tw <= {2'b00, trex_w};
        r_th <= {2'b00, trex_h};
        r_ox <= {obstacle_x[10], obstacle_x};
        r_oy <= {2'b00, obstacle_y};
        r_ow <= {2'b00, obstacle_w};
        r_oh <= {2'b00, obstacle_h};
        r_i  <= '0;
        r_j  <= '0;
      end else if (r_state == S_PAIRS && enable && !w_overlap && !w_last) begin
        // j is the inner loop, i the outer.
        if (r_j == c_last_j) begin
          r_j <= '0;
          r_i <= r_i + 3'd1;
        end else begin
          r_j <= r_j + 3'd1;
        end
      end

      // A restart clear takes priority over a hit found in the same cycle.
      if (clear) begin
        r_crash <= 1'b0;
        r_hit_i <= '0;
        r_hit_j <= '0;
      end else if (w_pair_hit) begin
        r_crash <= 1'b1;
        r_hit_i <= r_i;
        r_hit_j <= r_j;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FINISH) || r_nv_done;
  assign crash        = r_crash;
  assign hit_trex_idx = r_hit_i;
  assign hit_obst_idx = r_hit_j;

endmodule
`default_nettype wire

// File: tb/tb_collision_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_checker
//  Description : Scoreboard bench for collision_checker. Directed scenarios
//                plus randomized frames scored against a plain geometric
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_checker;

  localparam int TREX_BOXES = 6;
  localparam int OBST_BOXES = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic update = 1'b0, enable = 1'b1, clear = 1'b0, obstacle_valid = 1'b1;
  logic signed [10:0] trex_x = '0, obstacle_x = '0;
  logic [9:0] trex_y = '0, trex_w = '0, trex_h = '0;
  logic [9:0] obstacle_y = '0, obstacle_w = '0, obstacle_h = '0;
  collision_pkg::collision_box_t trex_box [TREX_BOXES];
  collision_pkg::collision_box_t obstacle_box [OBST_BOXES];
  logic busy, done, crash;
  logic [2:0] hit_trex_idx, hit_obst_idx;

  collision_checker #(.TREX_BOXES(TREX_BOXES), .OBST_BOXES(OBST_BOXES)) dut (
    .clk(clk), .rst(rst), .update(update), .enable(enable), .clear(clear),
    .obstacle_valid(obstacle_valid),
    .trex_x(trex_x), .trex_y(trex_y), .trex_w(trex_w), .trex_h(trex_h),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .obstacle_w(obstacle_w), .obstacle_h(obstacle_h),
    .trex_box(trex_box), .obstacle_box(obstacle_box),
    .busy(busy), .done(done), .crash(crash),
    .hit_trex_idx(hit_trex_idx), .hit_obst_idx(hit_obst_idx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int cr;
    int ti;
    int oi;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("crash", int'(crash), e.cr);
        chk("hit_trex_idx", int'(hit_trex_idx), e.ti);
        chk("hit_obst_idx", int'(hit_obst_idx), e.oi);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic issue(input int lat, input int cr, input int ti, input int oi);
    exp_t e;
    e.cyc = cyc + lat;
    e.cr  = cr;
    e.ti  = ti;
    e.oi  = oi;
    sb.push_back(e);
    pulse_update();
  endtask

  task automatic wait_sb(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
      sb.delete();
    end
    tick();
  endtask

  task automatic sample_chk(input string name, input int act_sel, input int exp);
    int a;
    @(negedge clk);
    case (act_sel)
      0: a = int'(busy);
      1: a = int'(crash);
      2: a = int'(done);
      3: a = int'(hit_trex_idx);
      default: a = int'(hit_obst_idx);
    endcase
    chk(name, a, exp);
  endtask

  task automatic zero_boxes();
    for (int i = 0; i < TREX_BOXES; i++) trex_box[i] = '0;
    for (int j = 0; j < OBST_BOXES; j++) obstacle_box[j] = '0;
  endtask

  task automatic set_outer(input int tx, input int ty, input int tw, input int th,
                           input int ox, input int oy, input int ow, input int oh);
    trex_x = 11'(tx); trex_y = 10'(ty); trex_w = 10'(tw); trex_h = 10'(th);
    obstacle_x = 11'(ox); obstacle_y = 10'(oy); obstacle_w = 10'(ow); obstacle_h = 10'(oh);
  endtask

  // Reference model: plain rectangle arithmetic over the whole frame.
  function automatic bit rect_hit(input int ax, input int ay, input int aw, input int ah,
                                  input int bx, input int by, input int bw, input int bh);
    return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
  endfunction

  task automatic model(output int lat, output int cr, output int ti, output int oi);
    int tx, ty, ox, oy;
    tx = int'(trex_x);
    ty = int'(trex_y);
    ox = int'(obstacle_x);
    oy = int'(obstacle_y);
    lat = 2; cr = 0; ti = 0; oi = 0;
    if (!obstacle_valid) begin
      lat = 1;
      return;
    end
    if (!rect_hit(tx + 1, ty + 1, int'(trex_w) - 2, int'(trex_h) - 2,
                  ox + 1, oy + 1, int'(obstacle_w) - 2, int'(obstacle_h) - 2))
      return;
    for (int k = 0; k < TREX_BOXES * OBST_BOXES; k++) begin
      collision_pkg::collision_box_t a, b;
      a = trex_box[k / OBST_BOXES];
      b = obstacle_box[k % OBST_BOXES];
      if (a.w != 0 && a.h != 0 && b.w != 0 && b.h != 0 &&
          rect_hit(tx + int'(a.x), ty + int'(a.y), int'(a.w), int'(a.h),
                   ox + int'(b.x), oy + int'(b.y), int'(b.w), int'(b.h))) begin
        lat = 3 + k; cr = 1; ti = k / OBST_BOXES; oi = k % OBST_BOXES;
        return;
      end
    end
    lat = 2 + TREX_BOXES * OBST_BOXES;
  endtask

  // Single trex_box[1] / obstacle_box[2] overlap (pair index 7).
  task automatic setup_pair12(input int ox);
    zero_boxes();
    set_outer(50, 100, 44, 47, ox, 100, 17, 35);
    trex_box[1]     = {8'd10, 8'd10, 8'd10, 8'd10};
    obstacle_box[2] = {8'd10, 8'd15, 8'd5, 8'd5};
  endtask

  // Outer overlap, but the only boxes never meet: full pair sweep.
  task automatic setup_sweep();
    zero_boxes();
    set_outer(50, 100, 44, 47, 60, 100, 17, 35);
    trex_box[0]     = {8'd22, 8'd0, 8'd17, 8'd16};
    obstacle_box[0] = {8'd0, 8'd0, 8'd5, 8'd35};
  endtask

  initial begin
    int lat, cr, ti, oi;
    zero_boxes();

    // Reset state
    rst = 1'b0;
    tick(); tick();
    sample_chk("reset_busy", 0, 0);
    sample_chk("reset_done", 2, 0);
    sample_chk("reset_crash", 1, 0);
    sample_chk("reset_hit_trex_idx", 3, 0);
    sample_chk("reset_hit_obst_idx", 4, 0);
    tick();
    rst = 1'b1;
    tick();

    // Outer miss, busy for exactly two cycles
    zero_boxes();
    set_outer(50, 100, 44, 47, 300, 105, 17, 35);
    issue(2, 0, 0, 0);
    sample_chk("outer_miss_busy1", 0, 1);
    tick();
    sample_chk("outer_miss_busy2", 0, 1);
    tick();
    sample_chk("outer_miss_busy_end", 0, 0);
    wait_sb(40);

    // Outer overlap, full sweep without a hit
    setup_sweep();
    issue(32, 0, 0, 0);
    wait_sb(40);

    // Hit on pair (1,2); obstacle box left edge at 70 touches trex box right edge at 70
    setup_pair12(60);
    issue(32, 0, 0, 0);
    wait_sb(40);
    // One pixel left: overlap
    setup_pair12(59);
    issue(10, 1, 1, 2);
    wait_sb(40);
    clear = 1'b1; tick(); clear = 1'b0;
    sample_chk("clear_crash", 1, 0);
    sample_chk("clear_hit_trex_idx", 3, 0);

    // No visible obstacle: done next cycle, no crash
    obstacle_valid = 1'b0;
    issue(1, 0, 0, 0);
    wait_sb(10);
    obstacle_valid = 1'b1;

    // Negative obstacle x: hit on pair 0
    zero_boxes();
    set_outer(0, 100, 44, 47, -10, 100, 25, 35);
    trex_box[0]     = {8'd0, 8'd0, 8'd10, 8'd10};
    obstacle_box[0] = {8'd0, 8'd0, 8'd12, 8'd35};
    issue(3, 1, 0, 0);
    wait_sb(40);
    // Update while crashed is ignored
    pulse_update();
    sample_chk("crashed_update_ignored", 0, 0);
    tick(); tick(); tick();
    sample_chk("crash_sticky", 1, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    sample_chk("clear_after_neg", 1, 0);
    set_outer(50, 100, 44, 47, 300, 105, 17, 35);
    issue(2, 0, 0, 0);
    wait_sb(40);

    // Clear coinciding with the hit: clear wins, done still reported
    setup_pair12(59);
    issue(10, 0, 0, 0);
    repeat (8) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    wait_sb(40);

    // Reset zeroes a sticky crash
    issue(10, 1, 1, 2);
    wait_sb(40);
    rst = 1'b0; tick(); rst = 1'b1;
    sample_chk("reset_clears_crash", 1, 0);

    // Reset during PAIRS: back to idle, no done
    setup_sweep();
    pulse_update();
    repeat (5) tick();
    sample_chk("pairs_busy_before_reset", 0, 1);
    rst = 1'b0; tick(); rst = 1'b1;
    sample_chk("reset_in_pairs_busy", 0, 0);
    repeat (35) tick();

    // enable drop during PAIRS: abort, no done
    pulse_update();
    repeat (5) tick();
    enable = 1'b0; tick(); enable = 1'b1;
    sample_chk("enable_drop_busy", 0, 0);
    sample_chk("enable_drop_crash", 1, 0);
    repeat (35) tick();

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      int t;
      set_outer(int'($urandom_range(0, 100)), int'($urandom_range(50, 150)),
                int'($urandom_range(10, 60)), int'($urandom_range(10, 60)),
                int'($urandom_range(0, 250)) - 50, int'($urandom_range(50, 150)),
                int'($urandom_range(10, 60)), int'($urandom_range(10, 60)));
      for (int i = 0; i < TREX_BOXES; i++)
        trex_box[i] = {8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)),
                       ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20)),
                       8'($urandom_range(1, 20))};
      for (int j = 0; j < OBST_BOXES; j++)
        obstacle_box[j] = {8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)),
                           8'($urandom_range(1, 20)),
                           ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20))};
      obstacle_valid = ($urandom_range(0, 9) != 0);
      model(lat, cr, ti, oi);
      issue(lat, cr, ti, oi);
      t = int'($urandom_range(0, 1));
      if (lat > 6 && t == 1) begin
        // A second update while busy must be ignored.
        tick(); tick();
        pulse_update();
      end
      wait_sb(40);
      if (cr == 1) begin
        clear = 1'b1; tick(); clear = 1'b0;
        sample_chk("random_clear", 1, 0);
      end
      obstacle_valid = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
